// File: rtl/fifo_rr_scheduler.sv
// rtl/fifo_rr_scheduler.sv - round-robin drain of NUM_QUEUES FIFOs onto one registered output stream
// Optional strict priority for queue 0 when FIFO_RR_SCHED_PRIO0_EN is defined.
module fifo_rr_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_QUEUES = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_QUEUES-1:0]            q_empty,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] q_data,
    output logic [NUM_QUEUES-1:0]            q_drop,
    output logic [DATA_WIDTH-1:0]            data_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [NUM_QUEUES-1:0]            grant_o,
    output logic [$clog2(NUM_QUEUES)-1:0]    grant_id
);
    localparam int             PTR_W      = $clog2(NUM_QUEUES);
    localparam logic [PTR_W:0] NQ         = (PTR_W+1)'(NUM_QUEUES);
    localparam logic [7:0]     BURST_LAST = 8'(BURST_LEN - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [PTR_W-1:0]      rr_ptr, ptr_nxt, pick, gid_nxt, ptr_inc, rot_ptr;
    logic [PTR_W:0]        idx, inc_w;
    logic [7:0]            burst_cnt, cnt_nxt;
    logic [NUM_QUEUES-1:0] grant_nxt;
    logic [DATA_WIDTH-1:0] data_nxt, head_data;
    logic                  valid_nxt, found, head_empty, load, prio_break;

    // First non-empty queue at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx >= NQ) begin
                idx = idx - NQ;
            end
            if (!found && !q_empty[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[PTR_W-1:0];
            end
        end
`ifdef FIFO_RR_SCHED_PRIO0_EN
        if (!q_empty[0]) begin
            found = 1'b1;
            pick  = '0;
        end
`endif
    end

    assign inc_w      = {1'b0, grant_id} + (PTR_W+1)'(1);
    assign ptr_inc    = (inc_w == NQ) ? '0 : inc_w[PTR_W-1:0];
    assign head_empty = q_empty[grant_id];
    assign head_data  = q_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    // Drops are suppressed during reset so a queue never loses a word the scheduler will discard.
    assign load       = (state == DRAIN) && !rst && (!valid_o || ready_i) && !head_empty;

`ifdef FIFO_RR_SCHED_PRIO0_EN
    assign prio_break = (state == DRAIN) && (grant_id != '0) && !q_empty[0] && (burst_cnt != '0);
    assign rot_ptr    = (grant_id == '0) ? rr_ptr : ptr_inc;
`else
    assign prio_break = 1'b0;
    assign rot_ptr    = ptr_inc;
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        gid_nxt   = grant_id;
        ptr_nxt   = rr_ptr;
        cnt_nxt   = burst_cnt;
        data_nxt  = data_o;
        valid_nxt = valid_o && !ready_i;
        q_drop    = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt       = DRAIN;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    gid_nxt         = pick;
                    cnt_nxt         = '0;
                end
            end
            DRAIN: begin
                if (load) begin
                    q_drop[grant_id] = 1'b1;
                    data_nxt         = head_data;
                    valid_nxt        = 1'b1;
                    cnt_nxt          = burst_cnt + 8'd1;
                end
                if (head_empty || (load && burst_cnt == BURST_LAST) || prio_break) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = rot_ptr;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_o   <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            data_o    <= '0;
            valid_o   <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_o   <= grant_nxt;
            grant_id  <= gid_nxt;
            rr_ptr    <= ptr_nxt;
            burst_cnt <= cnt_nxt;
            data_o    <= data_nxt;
            valid_o   <= valid_nxt;
        end
    end
endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Round-robin scheduler that drains up to NUM_QUEUES fifo_cl instances onto one shared output stream.
- Per queue, it reads the empty flag and head data and issues level-sensitive, single-cycle drop pulses.
- Sits between a bank of per-source FIFOs and a single downstream consumer (e.g. a UART TX or bus master).
- Burst quota per grant bounds the latency any queue can impose on the others.

Parameters:
- DATA_WIDTH, 32, width of each entry; must match the drained FIFOs.
- NUM_QUEUES, 4, number of queues served; range 2..16.
- BURST_LEN, 4, maximum words drained per grant before rotating; range 1..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- q_empty  input  NUM_QUEUES  fifo_empty of each queue; bit i = queue i.
- q_data  input  NUM_QUEUES*DATA_WIDTH  head data (data_o) of each queue; queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- q_drop  output  NUM_QUEUES  drop pulse per queue; at most one bit set per cycle.
- data_o  output  DATA_WIDTH  registered output word.
- valid_o  output  1  data_o holds a word.
- ready_i  input  1  consumer accepts data_o this cycle when valid_o=1.
- grant_o  output  NUM_QUEUES  one-hot current grant; all zero when idle.
- grant_id  output  clog2(NUM_QUEUES)  index of the granted queue; holds the last value when idle.

Behaviour:
- Reset values: q_drop=0, valid_o=0, data_o=0, grant_o=0, grant_id=0, rr_ptr=0, burst_cnt=0, state=IDLE.
- FSM has two states, IDLE and DRAIN.
- IDLE:
  - Search q_empty from rr_ptr upward with wrap-around; select the first queue i with q_empty[i]=0.
  - If one is found: next cycle state=DRAIN, grant_o=1<<i, grant_id=i, burst_cnt=0.
  - If none is found: stay in IDLE.
  - No drop is issued in IDLE, so grant latency is 1 cycle.
- DRAIN with granted queue g:
  - Output slot free = (~valid_o | ready_i).
  - If slot free and q_empty[g]=0: data_o<=q_data[g], valid_o<=1, q_drop[g]=1 this cycle (combinational), burst_cnt<=burst_cnt+1.
  - If slot free and the queue is empty: valid_o<=0.
  - If slot not free: hold data_o, valid_o and burst_cnt; no drop.
- Rotation (DRAIN -> IDLE):
  - Trigger: burst_cnt reaches BURST_LEN after a load, or q_empty[g]=1 while DRAIN is active.
  - On the transition: grant_o<=0 and rr_ptr<=(g+1) mod NUM_QUEUES.
  - The output register is independent of the FSM; a pending valid_o word stays until ready_i.
- Throughput: back-to-back drops on consecutive cycles are legal.
  - fifo_cl updates fifo_empty one cycle after a drop, so the q_empty[g] sampled the next cycle is already current.
  - Sustained rate is 1 word/cycle while ready_i=1.
  - Each rotation costs 1 idle cycle.
- Never drop an empty queue; never assert more than one q_drop bit.
- Pushes into the granted queue during DRAIN are served within the same burst, up to BURST_LEN.
- Output ordering: per-queue FIFO order is preserved. Between queues the order is round-robin by grant.
- Reset mid-burst: all state clears next edge.
  - A word in data_o is discarded; the scheduler does not re-queue it.
  - Queues are unaffected unless reset together.
- ready_i with valid_o=0 is ignored.

Optional Feature:
- Macro: FIFO_RR_SCHED_PRIO0_EN.
- When defined, queue 0 is strict-priority:
  - The IDLE search always checks queue 0 first, ahead of the rr_ptr search.
  - In DRAIN of any g≠0, the burst terminates early once q_empty[0]=0 is observed after at least one word of the burst has been loaded.
  - rr_ptr is not advanced by queue-0 grants.
- When undefined, pure round-robin as above, with no extra logic.

Test Plan:
- Reset, then all queues empty -> grant_o=0, valid_o=0, q_drop=0 for 20 cycles.
- Queue 2 holds 3 words {A,B,C}, ready_i=1 -> grant_id=2 one cycle after q_empty[2] falls; q_drop[2] pulses 3 consecutive cycles; data_o sequence is A,B,C; then IDLE and rr_ptr=3.
- Queues 0 and 1 each hold 10 words, BURST_LEN=4 -> output order is q0×4, q1×4, q0×4, q1×4, q0×2, q1×2, with one gap cycle per rotation.
- Backpressure: ready_i=0 for 5 cycles mid-burst -> data_o/valid_o stable, no q_drop, burst_cnt frozen; resumes with no loss or duplication.
- rr_ptr wrap: NUM_QUEUES=4, only queue 3 then queue 0 non-empty -> grants 3 then 0, rr_ptr goes 0→0 (after q3)→1.
- With FIFO_RR_SCHED_PRIO0_EN: queue 1 bursting 4 words, queue 0 becomes non-empty after word 2 -> burst ends after word 2 or 3; queue 0 granted next, then queue 1 resumes.
